regfile_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 16x8 register file. It accepts single-beat read and write commands from two requesters, for example the digit-scan controller and a host or debug port. It serialises the commands onto the register file's single read/write port set and returns read data to the requester that issued the read. Selection is round-robin, with a bounded lock so one requester can run an uninterrupted read-modify-write sequence.

---
 rtl/regfile_arbiter_if.sv | 47 ++++
 rtl/regfile_arbiter.sv | 171 +++++++++++++++++
 tb/tb_regfile_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_arbiter_if
//  Description : Bundle of the two requester command/response channels and the
//                register-file port driven by the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_arbiter_if ();
    // Requester command channels
    logic       req0,   req1;
    logic       we0,    we1;
    logic       lock0,  lock1;
    logic [3:0] addr0,  addr1;
    logic [7:0] wdata0, wdata1;

    // Requester response channels
    logic       gnt0,    gnt1;
    logic       rvalid0, rvalid1;
    logic [7:0] rdata;

    // Register-file port
    logic [3:0] rf_raddr;
    logic [3:0] rf_waddr;
    logic       rf_ren;
    logic       rf_wen;
    logic [7:0] rf_wdata;
    logic [7:0] rf_rdata;

    // Requesters plus the register file itself
    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  rf_raddr, rf_waddr, rf_ren, rf_wen, rf_wdata,
        output rf_rdata
    );

    // The arbiter
    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output rf_raddr, rf_waddr, rf_ren, rf_wen, rf_wdata,
        input  rf_rdata
    );
endinterface
`default_nettype wire

// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_arbiter
//  Description : Round-robin arbiter/sequencer putting single-beat commands from
//                two requesters onto the shared 16x8 register-file port, with a
//                bounded lock for uninterrupted read-modify-write sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_arbiter #(
    parameter int LOCK_MAX = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    regfile_arbiter_if.slave bus
);

    localparam logic [3:0] c_lock_max = 4'(LOCK_MAX);

    typedef enum logic [1:0] {
        ST_OPEN  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_lcnt,  w_lcnt_nxt, w_lcnt_inc;
    logic       r_last,  w_last_nxt;
    logic       w_gnt0,  w_gnt1, w_gnt;

    logic       w_we;
    logic [3:0] w_addr;
    logic [7:0] w_wdata;

    logic [3:0] r_raddr, r_waddr;
    logic [7:0] r_wdata, r_rdata;
    logic       r_ren, r_wen, r_rd_port;
    logic       r_rvalid0, r_rvalid1;

    assign w_lcnt_inc = r_lcnt + 4'd1;

    // Grant selection and lock-tenure bookkeeping; r_lcnt counts the grants of
    // the current tenure, and the grant that brings it to LOCK_MAX ends it.
    always_comb begin
        w_state_nxt = r_state;
        w_lcnt_nxt  = r_lcnt;
        w_last_nxt  = r_last;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        if (Rst) begin
            case (r_state)
                ST_OPEN: begin
                    if (bus.req0 && (!bus.req1 || r_last)) begin
                        w_gnt0 = 1'b1;
                    end else if (bus.req1) begin
                        w_gnt1 = 1'b1;
                    end
                    if (w_gnt0) begin
                        w_last_nxt = 1'b0;
                        if (bus.lock0 && (c_lock_max > 4'd1)) begin
                            w_state_nxt = ST_LOCK0;
                            w_lcnt_nxt  = 4'd1;
                        end
                    end
                    if (w_gnt1) begin
                        w_last_nxt = 1'b1;
                        if (bus.lock1 && (c_lock_max > 4'd1)) begin
                            w_state_nxt = ST_LOCK1;
                            w_lcnt_nxt  = 4'd1;
                        end
                    end
                end
                ST_LOCK0: begin
                    w_state_nxt = ST_OPEN;
                    w_lcnt_nxt  = 4'd0;
                    if (bus.req0) begin
                        w_gnt0     = 1'b1;
                        w_last_nxt = 1'b0;
                        if (bus.lock0 && (w_lcnt_inc < c_lock_max)) begin
                            w_state_nxt = ST_LOCK0;
                            w_lcnt_nxt  = w_lcnt_inc;
                        end
                    end
                end
                ST_LOCK1: begin
                    w_state_nxt = ST_OPEN;
                    w_lcnt_nxt  = 4'd0;
                    if (bus.req1) begin
                        w_gnt1     = 1'b1;
                        w_last_nxt = 1'b1;
                        if (bus.lock1 && (w_lcnt_inc < c_lock_max)) begin
                            w_state_nxt = ST_LOCK1;
                            w_lcnt_nxt  = w_lcnt_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_OPEN;
                    w_lcnt_nxt  = 4'd0;
                end
            endcase
        end
    end

    assign w_gnt   = w_gnt0 | w_gnt1;
    assign w_we    = w_gnt1 ? bus.we1    : bus.we0;
    assign w_addr  = w_gnt1 ? bus.addr1  : bus.addr0;
    assign w_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;

    // Arbitration state register
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= ST_OPEN;
            r_lcnt  <= 4'd0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_lcnt  <= w_lcnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Launch the accepted command onto the register-file port for one cycle
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_raddr   <= 4'd0;
            r_waddr   <= 4'd0;
            r_wdata   <= 8'd0;
            r_ren     <= 1'b0;
            r_wen     <= 1'b0;
            r_rd_port <= 1'b0;
        end else if (w_gnt) begin
            r_raddr   <= w_addr;
            r_waddr   <= w_addr;
            r_wdata   <= w_wdata;
            r_ren     <= ~w_we;
            r_wen     <= w_we;
            r_rd_port <= w_gnt1;
        end else begin
            r_ren     <= 1'b0;
            r_wen     <= 1'b0;
        end
    end

    // Capture read data and steer the valid pulse back to the issuing port
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= 8'd0;
        end else begin
            r_rvalid0 <= r_ren & ~r_rd_port;
            r_rvalid1 <= r_ren &  r_rd_port;
            if (r_ren) begin
                r_rdata <= bus.rf_rdata;
            end
        end
    end

    assign bus.gnt0     = w_gnt0;
    assign bus.gnt1     = w_gnt1;
    assign bus.rvalid0  = r_rvalid0;
    assign bus.rvalid1  = r_rvalid1;
    assign bus.rdata    = r_rdata;
    assign bus.rf_raddr = r_raddr;
    assign bus.rf_waddr = r_waddr;
    assign bus.rf_ren   = r_ren;
    assign bus.rf_wen   = r_wen;
    assign bus.rf_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_arbiter
//  Description : Self-checking bench for regfile_arbiter: directed scenarios
//                followed by random traffic, checked every cycle against a
//                transaction-level model of arbitration and register contents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_arbiter;

    localparam int LOCK_MAX = 4;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    regfile_arbiter_if bus ();

    regfile_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    // Requester drive state
    logic       req   [2];
    logic       we    [2];
    logic       lock  [2];
    logic [3:0] addr  [2];
    logic [7:0] wdata [2];

    assign bus.req0   = req[0];
    assign bus.req1   = req[1];
    assign bus.we0    = we[0];
    assign bus.we1    = we[1];
    assign bus.lock0  = lock[0];
    assign bus.lock1  = lock[1];
    assign bus.addr0  = addr[0];
    assign bus.addr1  = addr[1];
    assign bus.wdata0 = wdata[0];
    assign bus.wdata1 = wdata[1];

    // Register file environment
    logic [7:0] rf_mem [16];
    always @(posedge Clk) begin
        if (bus.rf_wen) rf_mem[bus.rf_waddr] <= bus.rf_wdata;
    end
    assign bus.rf_rdata = bus.rf_ren ? rf_mem[bus.rf_raddr] : 8'h00;

    // Reference model
    typedef struct {
        int         port;
        logic [7:0] data;
        int         due;
    } rd_t;

    int         m_owner;      // -1 when nobody holds a lock
    int         m_tenure;     // grants in the current lock tenure
    int         m_last;       // last granted port
    logic [7:0] m_mem [16];
    rd_t        rq [$];       // reads awaiting their data-return cycle
    logic       e_ren, e_wen;
    logic [3:0] e_addr;
    logic [7:0] e_wdata, e_rdata;

    int         cyc;
    int         n_pass;
    int         n_total;

    int         ghist [$];
    bit         rv0h  [$];
    bit         rv1h  [$];
    logic [7:0] rdh   [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_last   = 1;
        e_ren    = 1'b0;
        e_wen    = 1'b0;
        e_addr   = 4'd0;
        e_wdata  = 8'd0;
        e_rdata  = 8'd0;
        rq.delete();
    endtask

    function automatic int exp_grant();
        if (!Rst) return -1;
        if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
        if (req[0] && req[1]) return 1 - m_last;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    task automatic set_cmd(input int p, input logic r, input logic w, input logic l,
                           input logic [3:0] a, input logic [7:0] d);
        req[p]   = r;
        we[p]    = w;
        lock[p]  = l;
        addr[p]  = a;
        wdata[p] = d;
    endtask

    task automatic idle();
        set_cmd(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        set_cmd(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    // One clock: check all outputs mid-cycle, then advance the model at the edge
    task automatic step(input string tag, output int g);
        int  og;
        bit  ev0, ev1;
        @(negedge Clk);
        g   = exp_grant();
        og  = bus.gnt0 ? 0 : (bus.gnt1 ? 1 : -1);
        if (bus.gnt0 && bus.gnt1) og = 2;
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e_rdata = rq[0].data;
            if (rq[0].port == 0) ev0 = 1'b1; else ev1 = 1'b1;
            void'(rq.pop_front());
        end
        chk({tag, ".gnt"},      og,                 g);
        chk({tag, ".rf_ren"},   32'(bus.rf_ren),    32'(e_ren));
        chk({tag, ".rf_wen"},   32'(bus.rf_wen),    32'(e_wen));
        chk({tag, ".rf_raddr"}, 32'(bus.rf_raddr),  32'(e_addr));
        chk({tag, ".rf_waddr"}, 32'(bus.rf_waddr),  32'(e_addr));
        chk({tag, ".rf_wdata"}, 32'(bus.rf_wdata),  32'(e_wdata));
        chk({tag, ".rvalid0"},  32'(bus.rvalid0),   32'(ev0));
        chk({tag, ".rvalid1"},  32'(bus.rvalid1),   32'(ev1));
        chk({tag, ".rdata"},    32'(bus.rdata),     32'(e_rdata));
        ghist.push_back(og);
        rv0h.push_back(bus.rvalid0);
        rv1h.push_back(bus.rvalid1);
        rdh.push_back(bus.rdata);
        @(posedge Clk);
        if (!Rst) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                e_ren   = !we[g];
                e_wen   = we[g];
                e_addr  = addr[g];
                e_wdata = wdata[g];
                if (we[g]) m_mem[addr[g]] = wdata[g];
                else       rq.push_back('{g, m_mem[addr[g]], cyc + 2});
                m_last = g;
            end else begin
                e_ren = 1'b0;
                e_wen = 1'b0;
            end
            if (m_owner >= 0) begin
                if (g >= 0) begin
                    m_tenure++;
                    if (!lock[g] || m_tenure >= LOCK_MAX) begin
                        m_owner  = -1;
                        m_tenure = 0;
                    end
                end else begin
                    m_owner  = -1;
                    m_tenure = 0;
                end
            end else if (g >= 0 && lock[g] && LOCK_MAX > 1) begin
                m_owner  = g;
                m_tenure = 1;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int c0;
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        model_reset();

        // Reset: grants must stay low even with a request pending
        Rst = 1'b0;
        idle();
        req[0] = 1'b1;
        step("rst", g);
        step("rst", g);
        Rst = 1'b1;
        idle();

        // Single write then read of address 5
        c0 = cyc;
        set_cmd(0, 1'b1, 1'b1, 1'b0, 4'd5, 8'h39);
        step("wr5", g);
        set_cmd(0, 1'b1, 1'b0, 1'b0, 4'd5, 8'h00);
        step("rd5", g);
        idle();
        repeat (3) step("rd5.wait", g);
        chk("tp1.gnt_wr",  ghist[c0],        0);
        chk("tp1.gnt_rd",  ghist[c0 + 1],    0);
        chk("tp1.rvalid0", 32'(rv0h[c0 + 3]), 1);
        chk("tp1.rdata",   32'(rdh[c0 + 3]),  32'h39);
        chk("tp1.rvalid1", 32'(rv1h[c0 + 3]), 0);

        // Fill the whole register file with random values
        for (int a = 0; a < 16; a++) begin
            set_cmd(0, 1'b1, 1'b1, 1'b0, 4'(a), 8'($urandom_range(255)));
            step("fill", g);
        end
        idle();
        step("fill.end", g);

        // Conflict from reset: grants alternate starting with port 0
        Rst = 1'b0;
        step("rst2", g);
        Rst = 1'b1;
        c0 = cyc;
        set_cmd(0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        set_cmd(1, 1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
        repeat (4) step("rr", g);
        idle();
        repeat (3) step("rr.wait", g);
        chk("rr.g0",  ghist[c0],     0);
        chk("rr.g1",  ghist[c0 + 1], 1);
        chk("rr.g2",  ghist[c0 + 2], 0);
        chk("rr.g3",  ghist[c0 + 3], 1);
        chk("rr.rv0", 32'(rv0h[c0 + 2]), 1);
        chk("rr.rv1", 32'(rv1h[c0 + 3]), 1);
        chk("rr.rv2", 32'(rv0h[c0 + 4]), 1);
        chk("rr.rv3", 32'(rv1h[c0 + 5]), 1);

        // Lock tenure: port 1 holds for LOCK_MAX grants, then port 0 gets in
        c0 = cyc;
        set_cmd(1, 1'b1, 1'b0, 1'b1, 4'd2, 8'h00);
        step("lk", g);
        set_cmd(0, 1'b1, 1'b0, 1'b0, 4'd4, 8'h00);
        repeat (4) step("lk", g);
        idle();
        repeat (3) step("lk.wait", g);
        for (int i = 0; i < 4; i++) chk("lk.tenure", ghist[c0 + i], 1);
        chk("lk.release", ghist[c0 + 4], 0);

        // Lock released by an idle cycle of the owner
        c0 = cyc;
        set_cmd(0, 1'b1, 1'b0, 1'b1, 4'd6, 8'h00);
        step("idl", g);
        set_cmd(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        set_cmd(1, 1'b1, 1'b0, 1'b0, 4'd7, 8'h00);
        step("idl", g);
        step("idl", g);
        idle();
        repeat (3) step("idl.wait", g);
        chk("idl.lock", ghist[c0],     0);
        chk("idl.none", ghist[c0 + 1], -1);
        chk("idl.gnt1", ghist[c0 + 2], 1);

        // Read-modify-write under lock with port 1 contending
        set_cmd(1, 1'b1, 1'b1, 1'b0, 4'd3, 8'h35);
        step("rmw.init", g);
        idle();
        step("rmw.init", g);
        c0 = cyc;
        set_cmd(0, 1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
        set_cmd(1, 1'b1, 1'b0, 1'b0, 4'd8, 8'h00);
        step("rmw.rd", g);
        set_cmd(0, 1'b1, 1'b1, 1'b0, 4'd3, 8'h35 - 8'd48);
        step("rmw.wr", g);
        set_cmd(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        step("rmw.p1", g);
        set_cmd(0, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
        step("rmw.chk", g);
        idle();
        repeat (3) step("rmw.wait", g);
        chk("rmw.g_rd",  ghist[c0],     0);
        chk("rmw.g_wr",  ghist[c0 + 1], 0);
        chk("rmw.old",   32'(rdh[c0 + 2]),  32'h35);
        chk("rmw.rv",    32'(rv0h[c0 + 5]), 1);
        chk("rmw.new",   32'(rdh[c0 + 5]),  32'h05);

        // Reset one edge after a read grant drops the read
        c0 = cyc;
        set_cmd(0, 1'b1, 1'b0, 1'b0, 4'd9, 8'h00);
        step("rstrd", g);
        idle();
        req[1] = 1'b1;
        Rst = 1'b0;
        step("rstrd.rst", g);
        Rst = 1'b1;
        idle();
        step("rstrd.post", g);
        chk("rstrd.rv0",   32'(rv0h[c0 + 2]), 0);
        chk("rstrd.rdata", 32'(rdh[c0 + 2]),  0);
        chk("rstrd.gnt_in_rst", ghist[c0 + 1], -1);
        c0 = cyc;
        set_cmd(0, 1'b1, 1'b0, 1'b0, 4'd10, 8'h00);
        set_cmd(1, 1'b1, 1'b0, 1'b0, 4'd11, 8'h00);
        step("rstrd.rr", g);
        idle();
        repeat (3) step("rstrd.wait", g);
        chk("rstrd.first", ghist[c0], 0);

        // Random traffic: each requester holds its command until granted
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req[p] && $urandom_range(2) != 0) begin
                    set_cmd(p, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)),
                            4'($urandom_range(15)), 8'($urandom_range(255)));
                end
            end
            step("rnd", g);
            if (g >= 0) req[g] = 1'b0;
        end
        idle();
        repeat (3) step("rnd.wait", g);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
